// File: rtl/ransac_mem_reader_pkg.sv
// Shared types and constants for the RANSAC data-memory reader.
// Optional checksum output is enabled with RANSAC_READER_CHECKSUM_EN.
package ransac_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/ransac_mem_reader_if.sv
// Avalon-MM read bus plus the outgoing valid/ready word stream.
// The reader drives the master modport; memory and consumer sit on the slave side.
interface ransac_mem_reader_if;
    import ransac_mem_pkg::*;

    addr_t      avm_address;
    logic       avm_read;
    logic [3:0] avm_byteenable;
    logic       avm_waitrequest;
    word_t      avm_readdata;

    word_t      st_data;
    logic       st_valid;
    logic       st_ready;

    modport master (
        output avm_address, avm_read, avm_byteenable, st_data, st_valid,
        input  avm_waitrequest, avm_readdata, st_ready
    );

    modport slave (
        input  avm_address, avm_read, avm_byteenable, st_data, st_valid,
        output avm_waitrequest, avm_readdata, st_ready
    );

endinterface

// File: rtl/ransac_mem_reader_sync_fifo.sv
// Show-ahead synchronous FIFO: head is valid whenever the FIFO is non-empty.
// Push while full is accepted only if a pop frees the slot in the same cycle.
module ransac_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] used
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (used == '0);
    assign full    = (used == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            used <= used + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage is left unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ransac_mem_reader.sv
// Avalon-MM block read master feeding fetched words in address order onto a stream.
// Define RANSAC_READER_CHECKSUM_EN to add a running 32-bit sum of popped words.
module ransac_mem_reader
    import ransac_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  addr_t       base_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
`ifdef RANSAC_READER_CHECKSUM_EN
    output logic [31:0] checksum,
`endif
    ransac_mem_reader_if.master bus
);

    localparam int USED_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int CREDIT_W = USED_W + 1;

    state_t                  state;
    addr_t                   address_q;
    logic                    read_q;
    logic [15:0]             count_q;
    logic [15:0]             issued;
    logic [15:0]             issued_next;
    logic [USED_W-1:0]       outstanding;
    logic [READ_LATENCY-1:0] ret_pipe;
    logic [CREDIT_W-1:0]     credit_next;

    logic                    accept;
    logic                    ret_valid;
    logic                    pop;
    logic                    can_issue;
    logic                    fifo_full_unused;
    logic                    fifo_empty;
    logic [USED_W-1:0]       fifo_used;
    word_t                   fifo_head;

    assign accept      = read_q & ~bus.avm_waitrequest;
    assign ret_valid   = ret_pipe[READ_LATENCY-1];
    assign pop         = ~fifo_empty & bus.st_ready;
    assign issued_next = issued + 16'(accept);

    // Buffered plus in-flight words after this edge must leave room for one more read.
    assign credit_next = CREDIT_W'(fifo_used) + CREDIT_W'(outstanding)
                       + CREDIT_W'(accept) - CREDIT_W'(pop);
    assign can_issue   = (issued_next < count_q) &&
                         (credit_next < CREDIT_W'(FIFO_DEPTH));

    assign bus.avm_address    = address_q;
    assign bus.avm_read       = read_q;
    assign bus.avm_byteenable = 4'hF;
    assign bus.st_data        = fifo_head;
    assign bus.st_valid       = ~fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_pipe    <= '0;
            outstanding <= '0;
        end else begin
            ret_pipe[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                ret_pipe[i] <= ret_pipe[i-1];
            end
            outstanding <= outstanding + USED_W'(accept) - USED_W'(ret_valid);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            read_q    <= 1'b0;
            address_q <= '0;
            count_q   <= '0;
            issued    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count_q   <= word_count;
                        issued    <= '0;
                        address_q <= base_addr;
                        busy      <= 1'b1;
                        if (word_count != 16'd0) begin
                            state  <= ISSUE;
                            read_q <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // A stalled request keeps its address because accept stays low.
                    issued <= issued_next;
                    read_q <= can_issue;
                    if (accept) address_q <= address_q + addr_t'(1);
                    if (issued == count_q) state <= DRAIN;
                end
                DRAIN: begin
                    if (outstanding == '0 && fifo_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ransac_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ret_valid),
        .push_data (bus.avm_readdata),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .used      (fifo_used)
    );

`ifdef RANSAC_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + 32'(fifo_head);
        end
    end
`endif

endmodule

// File: tb/tb_ransac_mem_reader.sv
// Directed bench for ransac_mem_reader against a one-cycle-latency memory holding mem[i] = i*3.
// Checksum comparisons are included when RANSAC_READER_CHECKSUM_EN is defined.
module tb_ransac_mem_reader;
    import ransac_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    addr_t       base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
`ifdef RANSAC_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int    checks = 0;
    int    errors = 0;
    int    accept_cnt = 0;
    int    pop_cnt = 0;
    int    done_cnt = 0;
    addr_t addr_q[$];
    word_t data_q[$];

    ransac_mem_reader_if bus ();

    ransac_mem_reader #(
        .READ_LATENCY (1),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
`ifdef RANSAC_READER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic word_t mem_val(input addr_t a);
        return word_t'(a) * 32'd3;
    endfunction

    // Memory slave with one-cycle read latency, plus bus/stream activity logging.
    always @(posedge clk) begin
        if (bus.avm_read && !bus.avm_waitrequest) begin
            addr_q.push_back(bus.avm_address);
            bus.avm_readdata <= mem_val(bus.avm_address);
            accept_cnt++;
        end
        if (bus.st_valid && bus.st_ready) begin
            data_q.push_back(bus.st_data);
            pop_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic start_cmd(input addr_t b, input logic [15:0] n);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        bus.avm_waitrequest = 1'b0;
        bus.st_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", done); end
        checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read got %0b want 0", bus.avm_read); end
        checks++; if (bus.avm_address !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr got %h want 0000", bus.avm_address); end
        checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", bus.st_valid); end
        checks++; if (bus.st_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", bus.st_data); end
        checks++; if (bus.avm_byteenable !== 4'hF) begin errors++; $display("[TB] FAIL byteenable got %h want F", bus.avm_byteenable); end
`ifdef RANSAC_READER_CHECKSUM_EN
        checks++; if (checksum !== 32'd0) begin errors++; $display("[TB] FAIL reset_checksum got %0d want 0", checksum); end
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        data_q.delete();
        done_cnt = 0;
        start_cmd(16'h0010, 16'd5);
        checks++; if (bus.avm_read !== 1'b1) begin errors++; $display("[TB] FAIL basic_read_c1 got %0b want 1", bus.avm_read); end
        checks++; if (bus.avm_address !== 16'h0010) begin errors++; $display("[TB] FAIL basic_addr_c1 got %h want 0010", bus.avm_address); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %0b want 1", busy); end
        @(negedge clk);
        checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_c2 got %0b want 0", bus.st_valid); end
        @(negedge clk);
        checks++; if (bus.st_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_c3 got %0b want 1", bus.st_valid); end
        checks++; if (bus.st_data !== 32'd48) begin errors++; $display("[TB] FAIL basic_first_data got %0d want 48", bus.st_data); end
        wait_done(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_done_timeout got %0b want 1", ok); end
        checks++; if (data_q.size() !== 5) begin errors++; $display("[TB] FAIL basic_count got %0d want 5", data_q.size()); end
        for (int i = 0; i < 5; i++) begin
            word_t got = (i < data_q.size()) ? data_q[i] : 'x;
            word_t exp = 32'd48 + 32'(i) * 32'd3;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL basic_word%0d got %0d want %0d", i, got, exp); end
        end
`ifdef RANSAC_READER_CHECKSUM_EN
        checks++; if (checksum !== 32'd270) begin errors++; $display("[TB] FAIL basic_checksum got %0d want 270", checksum); end
`endif
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %0b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after got %0b want 0", busy); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_count;
        int acc0 = accept_cnt;
        start_cmd(16'h0020, 16'd0);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done got %0b want 1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy got %0b want 1", busy); end
        checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("[TB] FAIL zero_read got %0b want 0", bus.avm_read); end
`ifdef RANSAC_READER_CHECKSUM_EN
        checks++; if (checksum !== 32'd0) begin errors++; $display("[TB] FAIL zero_checksum got %0d want 0", checksum); end
`endif
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_after got %0b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_after got %0b want 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (accept_cnt !== acc0) begin errors++; $display("[TB] FAIL zero_reads got %0d want %0d", accept_cnt, acc0); end
    endtask

    task automatic test_wrap;
        bit    ok;
        addr_t exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        addr_q.delete();
        data_q.delete();
        start_cmd(16'hFFFE, 16'd4);
        wait_done(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL wrap_done_timeout got %0b want 1", ok); end
        checks++; if (addr_q.size() !== 4) begin errors++; $display("[TB] FAIL wrap_addr_count got %0d want 4", addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            addr_t ga = (i < addr_q.size()) ? addr_q[i] : 'x;
            word_t gd = (i < data_q.size()) ? data_q[i] : 'x;
            checks++; if (ga !== exp_a[i]) begin errors++; $display("[TB] FAIL wrap_addr%0d got %h want %h", i, ga, exp_a[i]); end
            checks++; if (gd !== mem_val(exp_a[i])) begin errors++; $display("[TB] FAIL wrap_data%0d got %0d want %0d", i, gd, mem_val(exp_a[i])); end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int acc0;
        data_q.delete();
        bus.st_ready = 1'b0;
        acc0 = accept_cnt;
        start_cmd(16'h0100, 16'd20);
        repeat (30) @(negedge clk);
        checks++; if (accept_cnt - acc0 !== 8) begin errors++; $display("[TB] FAIL bp_reads_before_pop got %0d want 8", accept_cnt - acc0); end
        checks++; if (data_q.size() !== 0) begin errors++; $display("[TB] FAIL bp_pops_while_stalled got %0d want 0", data_q.size()); end
        checks++; if (bus.st_data !== 32'd768) begin errors++; $display("[TB] FAIL bp_head got %0d want 768", bus.st_data); end
        bus.st_ready = 1'b1;
        wait_done(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL bp_done_timeout got %0b want 1", ok); end
        checks++; if (data_q.size() !== 20) begin errors++; $display("[TB] FAIL bp_count got %0d want 20", data_q.size()); end
        for (int i = 0; i < 20; i++) begin
            word_t got = (i < data_q.size()) ? data_q[i] : 'x;
            word_t exp = mem_val(addr_t'(16'h0100 + i));
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL bp_word%0d got %0d want %0d", i, got, exp); end
        end
    endtask

    task automatic test_waitrequest;
        bit    ok = 1'b0;
        bit    prev_stall = 1'b0;
        addr_t prev_addr = '0;
        word_t sum = '0;
        data_q.delete();
        bus.st_ready = 1'b1;
        start_cmd(16'h0200, 16'd12);
        for (int i = 0; i < 400; i++) begin
            if (prev_stall) begin
                checks++; if (bus.avm_read !== 1'b1) begin errors++; $display("[TB] FAIL wr_read_held got %0b want 1", bus.avm_read); end
                checks++; if (bus.avm_address !== prev_addr) begin errors++; $display("[TB] FAIL wr_addr_held got %h want %h", bus.avm_address, prev_addr); end
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
            bus.avm_waitrequest = 1'($urandom_range(0, 1));
            prev_stall = bus.avm_read && bus.avm_waitrequest;
            prev_addr  = bus.avm_address;
            @(negedge clk);
        end
        bus.avm_waitrequest = 1'b0;
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL wr_done_timeout got %0b want 1", ok); end
        checks++; if (data_q.size() !== 12) begin errors++; $display("[TB] FAIL wr_count got %0d want 12", data_q.size()); end
        for (int i = 0; i < 12; i++) begin
            word_t got = (i < data_q.size()) ? data_q[i] : 'x;
            word_t exp = mem_val(addr_t'(16'h0200 + i));
            sum += exp;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL wr_word%0d got %0d want %0d", i, got, exp); end
        end
`ifdef RANSAC_READER_CHECKSUM_EN
        checks++; if (checksum !== sum) begin errors++; $display("[TB] FAIL wr_checksum got %0d want %0d", checksum, sum); end
`endif
    endtask

    task automatic test_reset_mid;
        bit ok;
        bus.st_ready = 1'b0;
        start_cmd(16'h0300, 16'd3);
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_pre got %0b want 1", busy); end
        checks++; if (bus.st_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_valid_pre got %0b want 1", bus.st_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done got %0b want 0", done); end
        checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("[TB] FAIL mid_read got %0b want 0", bus.avm_read); end
        checks++; if (bus.avm_address !== 16'h0000) begin errors++; $display("[TB] FAIL mid_addr got %h want 0000", bus.avm_address); end
        checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %0b want 0", bus.st_valid); end
        checks++; if (bus.st_data !== 32'd0) begin errors++; $display("[TB] FAIL mid_data got %h want 0", bus.st_data); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus.st_ready = 1'b1;
        data_q.delete();
        start_cmd(16'h0000, 16'd2);
        wait_done(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL mid_done_timeout got %0b want 1", ok); end
        repeat (4) @(negedge clk);
        checks++; if (data_q.size() !== 2) begin errors++; $display("[TB] FAIL mid_count got %0d want 2", data_q.size()); end
        for (int i = 0; i < 2; i++) begin
            word_t got = (i < data_q.size()) ? data_q[i] : 'x;
            word_t exp = 32'(i) * 32'd3;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL mid_word%0d got %0d want %0d", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_backpressure();
        test_waitrequest();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
